// File: rtl/expected_in_serial_averager.sv
// Serial backward-path averager: accumulates M per-neuron expected_in vectors,
// divides every lane by M with a shared restoring divider, then hands the result out.
module expected_in_serial_averager #(
    parameter int N = 16,
    parameter int M = 36,
    parameter int W = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*W-1:0]       in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*W-1:0]       out_data,
    output logic [$clog2(M)-1:0] beat_idx,
    output logic                 busy
);
    localparam int CW    = $clog2(M);
    localparam int ACC_W = W + CW;
    localparam int SW    = $clog2(ACC_W + 1);

    localparam logic [CW:0]   DIVISOR   = (CW + 1)'(M);
    localparam logic [CW-1:0] LAST_BEAT = CW'(M - 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(ACC_W);

    typedef enum logic [1:0] {ACCUM, DIVIDE, OUTPUT} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc [N];
    logic [CW-1:0]    rem [N];
    logic [SW-1:0]    step;

    logic [CW:0]      rem_sh [N];
    logic [CW-1:0]    rem_nx [N];
    logic [N-1:0]     q_bit;

    // One restoring step per lane; the remainder stays below M, so CW bits hold it.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            rem_sh[i] = {rem[i], acc[i][ACC_W-1]};
            if (rem_sh[i] >= DIVISOR) begin
                q_bit[i]  = 1'b1;
                rem_nx[i] = CW'(rem_sh[i] - DIVISOR);
            end else begin
                q_bit[i]  = 1'b0;
                rem_nx[i] = rem_sh[i][CW-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ACCUM;
            beat_idx  <= '0;
            step      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                acc[i] <= '0;
                rem[i] <= '0;
            end
        end else if (flush) begin
            state     <= ACCUM;
            beat_idx  <= '0;
            step      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                acc[i] <= '0;
                rem[i] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        for (int unsigned i = 0; i < N; i++)
                            acc[i] <= acc[i] + ACC_W'(in_data[i*W +: W]);
                        if (beat_idx == LAST_BEAT) begin
                            beat_idx <= '0;
                            state    <= DIVIDE;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            beat_idx <= beat_idx + CW'(1);
                        end
                    end
                end
                DIVIDE: begin
                    // Quotient bits shift into acc from the bottom; after ACC_W steps acc holds the quotient.
                    if (step == LAST_STEP) begin
                        for (int unsigned i = 0; i < N; i++)
                            out_data[i*W +: W] <= acc[i][W-1:0];
                        out_valid <= 1'b1;
                        step      <= '0;
                        state     <= OUTPUT;
                    end else begin
                        for (int unsigned i = 0; i < N; i++) begin
                            acc[i] <= {acc[i][ACC_W-2:0], q_bit[i]};
                            rem[i] <= rem_nx[i];
                        end
                        step <= step + SW'(1);
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ACCUM;
                        for (int unsigned i = 0; i < N; i++) begin
                            acc[i] <= '0;
                            rem[i] <= '0;
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_expected_in_serial_averager.sv
// Bench for expected_in_serial_averager: table-driven frames, hand-written flush/reset
// sequences and random frames checked against a plain-arithmetic average model.
module tb_expected_in_serial_averager;
    localparam int N     = 16;
    localparam int M     = 36;
    localparam int W     = 16;
    localparam int ACC_W = W + $clog2(M);

    logic                 clock;
    logic                 reset_n;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*W-1:0]       in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*W-1:0]       out_data;
    logic [$clog2(M)-1:0] beat_idx;
    logic                 busy;

    expected_in_serial_averager #(.N(N), .M(M), .W(W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .beat_idx (beat_idx),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total  = 0;
    int passed = 0;

    logic [W-1:0] fr [M][N];
    logic [W-1:0] exp_lane [N];

    typedef struct {
        string        name;
        logic [W-1:0] fill;
        bit           floor_pat;
        int           gap_pct;
        logic [W-1:0] e0, e1, e2, erest;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    function automatic logic [N*W-1:0] pack(input int b);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = fr[b][i];
        return v;
    endfunction

    task automatic fill_const(input logic [W-1:0] v);
        for (int b = 0; b < M; b++)
            for (int i = 0; i < N; i++) fr[b][i] = v;
        for (int i = 0; i < N; i++) exp_lane[i] = v;
    endtask

    task automatic fill_table(input vec_t t);
        for (int b = 0; b < M; b++)
            for (int i = 0; i < N; i++) begin
                logic [W-1:0] v;
                v = t.fill;
                if (t.floor_pat) begin
                    if (i == 0)      v = W'(b);
                    else if (i == 1) v = '0;
                    else if (i == 2) v = (b == 0) ? W'(1) : W'(0);
                end
                fr[b][i] = v;
            end
        for (int i = 0; i < N; i++) exp_lane[i] = t.erest;
        exp_lane[0] = t.e0;
        exp_lane[1] = t.e1;
        exp_lane[2] = t.e2;
    endtask

    task automatic model_avg();
        for (int i = 0; i < N; i++) begin
            longint s;
            s = 0;
            for (int b = 0; b < M; b++) s += longint'(fr[b][i]);
            exp_lane[i] = W'(s / M);
        end
    endtask

    task automatic send_beats(input int gap_pct, input int n, output int acc_cyc);
        int bi_err;
        bi_err  = 0;
        acc_cyc = -1;
        for (int b = 0; b < n; b++) begin
            bit done;
            int tries;
            done  = 0;
            tries = 0;
            in_data = pack(b);
            while (!done) begin
                bit take;
                in_valid = ($urandom_range(99) >= gap_pct);
                take = in_valid && in_ready;
                @(posedge clock); #1;
                if (take) begin
                    done    = 1;
                    acc_cyc = cyc;
                    if (int'(beat_idx) != (b + 1) % M) bi_err++;
                end else begin
                    tries++;
                    if (tries > 500) begin
                        $display("FAIL send_timeout: beat %0d not accepted, in_ready=%0d expected 1", b, in_ready);
                        $fatal;
                    end
                end
            end
        end
        in_valid = 1'b0;
        check("beat_idx_track", bi_err, 0);
    endtask

    task automatic run_frame(input string name, input int gap_pct, input int hold);
        int             acc_cyc;
        int             lat;
        int             unstable;
        logic [N*W-1:0] first;
        send_beats(gap_pct, M, acc_cyc);
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock); #1;
            if (out_valid) begin
                lat = cyc - acc_cyc;
                break;
            end
        end
        check({name, "_latency"}, lat, ACC_W + 1);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_lane%0d", name, i), out_data[i*W +: W], exp_lane[i]);
        first    = out_data;
        unstable = 0;
        in_valid = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clock); #1;
            if (out_data !== first || !out_valid || in_ready || beat_idx != 0) unstable++;
        end
        in_valid = 1'b0;
        if (hold > 0) check({name, "_hold_stable"}, unstable, 0);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check({name, "_handshake"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        int a;
        int seen;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;

        tbl[0] = '{"all_ffff", 16'hFFFF, 1'b0, 0,  16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[1] = '{"floor",    16'd7,    1'b1, 0,  16'd17,   16'd0,    16'd0,    16'd7};
        tbl[2] = '{"gaps_100", 16'd100,  1'b0, 40, 16'd100,  16'd100,  16'd100,  16'd100};
        tbl[3] = '{"zero",     16'd0,    1'b0, 10, 16'd0,    16'd0,    16'd0,    16'd0};
        tbl[4] = '{"c1234",    16'h1234, 1'b0, 20, 16'h1234, 16'h1234, 16'h1234, 16'h1234};

        repeat (2) @(posedge clock);
        #1;
        check("reset_ctrl", {out_valid, in_ready, busy}, 3'b010);
        check("reset_beat_idx", beat_idx, 0);
        check("reset_out_data_zero", out_data == '0, 1);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Table frames; the first one also exercises 10 cycles of output backpressure.
        for (int t = 0; t < 5; t++) begin
            fill_table(tbl[t]);
            run_frame(tbl[t].name, tbl[t].gap_pct, (t == 0) ? 10 : 1);
        end

        // Flush at beat 20 with a beat presented in the same cycle.
        fill_const(16'd999);
        send_beats(0, 20, a);
        in_data  = pack(20);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clock); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_beat_idx", beat_idx, 0);
        check("flush_in_ready", in_ready, 1);
        fill_const(16'd50);
        run_frame("after_flush", 0, 0);

        // Flush during DIVIDE: no result may appear.
        fill_const(16'd77);
        send_beats(0, M, a);
        repeat (5) @(posedge clock);
        #1;
        check("divide_busy", busy, 1);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        check("divide_flush_no_out", seen, 0);
        check("divide_flush_ctrl", {in_ready, busy}, 2'b10);

        // Asynchronous reset between edges in the middle of DIVIDE.
        fill_const(16'd88);
        send_beats(0, M, a);
        repeat (5) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_ctrl", {out_valid, in_ready, busy}, 3'b010);
        check("async_rst_beat_idx", beat_idx, 0);
        #2;
        reset_n = 1'b1;
        @(posedge clock); #1;
        fill_const(16'd123);
        run_frame("after_reset", 0, 0);

        // Random frames against the average model.
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < M; b++)
                for (int i = 0; i < N; i++) fr[b][i] = W'($urandom_range(0, 65535));
            model_avg();
            run_frame($sformatf("rand%0d", r), 30, $urandom_range(0, 5));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
